// File: rtl/weight_mem_arbiter.sv
// rtl/weight_mem_arbiter.sv - arbitrated single-port tap-weight store with self-timed zero-fill
// Define WEIGHT_ARB_WRITE_PRIO_EN for fixed write priority on ties (default: round-robin).
module weight_mem_arbiter #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             rd_req,
   input  logic [AW-1:0]    rd_addr,
   output logic             rd_gnt,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_valid,
   input  logic             wr_req,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   output logic             wr_gnt,
   output logic             wr_done,
   input  logic             clr,
   output logic             busy
);

   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0]   DEPTH_A  = (AW+1)'(DEPTH);
   localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

   typedef enum logic [1:0] {IDLE, ACCESS, CLEAR} state_t;

   state_t           state_q, state_d;
   logic             acc_wr_q, acc_wr_d;
   logic             last_wr_q, last_wr_d;
   logic             clr_pending_q, clr_pending_d;
   logic [IW-1:0]    clr_addr_q, clr_addr_d;
   logic             rd_gnt_q, rd_gnt_d;
   logic             wr_gnt_q, wr_gnt_d;
   logic             rd_valid_q, rd_valid_d;
   logic             wr_done_q, wr_done_d;
   logic             busy_q, busy_d;
   logic [WIDTH-1:0] rd_data_q, rd_data_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];

   logic          rd_in_range, wr_in_range;
   logic [IW-1:0] rd_idx, wr_idx;

   assign rd_in_range = {1'b0, rd_addr} < DEPTH_A;
   assign wr_in_range = {1'b0, wr_addr} < DEPTH_A;
   assign rd_idx      = rd_addr[IW-1:0];
   assign wr_idx      = wr_addr[IW-1:0];

   always_comb begin
      state_d       = state_q;
      acc_wr_d      = acc_wr_q;
      last_wr_d     = last_wr_q;
      clr_pending_d = clr_pending_q;
      clr_addr_d    = clr_addr_q;
      rd_data_d     = rd_data_q;
      mem_d         = mem_q;
      rd_gnt_d      = 1'b0;
      wr_gnt_d      = 1'b0;
      rd_valid_d    = 1'b0;
      wr_done_d     = 1'b0;
      busy_d        = 1'b0;

      if (clr && (state_q != IDLE)) begin
         clr_pending_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (clr || clr_pending_q) begin
               state_d       = CLEAR;
               clr_addr_d    = '0;
               clr_pending_d = 1'b0;
               busy_d        = 1'b1;
            end else if (rd_req || wr_req) begin
               state_d = ACCESS;
               if (rd_req && wr_req) begin
`ifdef WEIGHT_ARB_WRITE_PRIO_EN
                  acc_wr_d = 1'b1;
`else
                  acc_wr_d  = !last_wr_q;
                  last_wr_d = !last_wr_q;
`endif
               end else begin
                  acc_wr_d = wr_req;
               end
               wr_gnt_d = acc_wr_d;
               rd_gnt_d = !acc_wr_d;
            end
         end
         ACCESS: begin
            state_d = IDLE;
            if (acc_wr_q) begin
               wr_done_d = 1'b1;
               // out-of-range writes still handshake but never touch storage
               if (wr_in_range) begin
                  mem_d[wr_idx] = wr_data;
               end
            end else begin
               rd_valid_d = 1'b1;
               rd_data_d  = rd_in_range ? mem_q[rd_idx] : '0;
            end
         end
         CLEAR: begin
            mem_d[clr_addr_q] = '0;
            if (clr_addr_q == LAST_IDX) begin
               state_d = IDLE;
            end else begin
               clr_addr_d = clr_addr_q + 1'b1;
               busy_d     = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         acc_wr_q      <= 1'b0;
         last_wr_q     <= 1'b1;
         clr_pending_q <= 1'b0;
         clr_addr_q    <= '0;
         rd_gnt_q      <= 1'b0;
         wr_gnt_q      <= 1'b0;
         rd_valid_q    <= 1'b0;
         wr_done_q     <= 1'b0;
         busy_q        <= 1'b0;
         rd_data_q     <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q       <= state_d;
         acc_wr_q      <= acc_wr_d;
         last_wr_q     <= last_wr_d;
         clr_pending_q <= clr_pending_d;
         clr_addr_q    <= clr_addr_d;
         rd_gnt_q      <= rd_gnt_d;
         wr_gnt_q      <= wr_gnt_d;
         rd_valid_q    <= rd_valid_d;
         wr_done_q     <= wr_done_d;
         busy_q        <= busy_d;
         rd_data_q     <= rd_data_d;
         mem_q         <= mem_d;
      end
   end

   assign rd_gnt   = rd_gnt_q;
   assign wr_gnt   = wr_gnt_q;
   assign rd_valid = rd_valid_q;
   assign wr_done  = wr_done_q;
   assign busy     = busy_q;
   assign rd_data  = rd_data_q;

endmodule
